cpu_mc: RTL

Parametrised multi-cycle successor to the single-clock core: a word-addressed, MIPS-style processor that steps each instruction through a Fetch / Decode / Execute / Memory / Writeback state machine. Instruction and data memories sit outside the core behind req/ack handshakes, so memories with any latency can be attached. It adds reset, a hardwired zero register, register-relative addressing, `bne`, `halt`, and retire/illegal status outputs.

---
 rtl/cpu_mc_pkg.sv | 46 ++++
 rtl/cpu_mc_alu.sv | 31 +++
 rtl/cpu_mc.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mc_pkg.sv
// cpu_mc shared definitions: opcodes, functs, field positions, FSM states.
// Decode helpers used by the top-level core.
package cpu_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LI    = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } cpu_state_e;

  function automatic logic op_legal(input logic [5:0] op,
                                    input logic [5:0] funct);
    if (op == OP_RTYPE)
      return funct inside {F_SLL, F_SRL, F_ADD, F_SUB,
                           F_AND, F_OR, F_SLT};
    return op inside {OP_J, OP_BEQ, OP_BNE, OP_LI,
                      OP_LW, OP_SW, OP_HALT};
  endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// cpu_mc combinational ALU.
// Shifts act on b (rt) by shamt; zero flag drives branch resolution.
module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (funct)
      F_ADD:   result = a + b;
      F_SUB:   result = a - b;
      F_AND:   result = a & b;
      F_OR:    result = a | b;
      F_SLT:   result = DATA_W'($signed(a) < $signed(b));
      F_SLL:   result = b << shamt;
      F_SRL:   result = b >> shamt;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle MIPS-style core with req/ack instruction and
// data memory ports, zero register, bne, halt and status pulses.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int IADDR_W = 12,
  parameter int DADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               retire,
  output logic               illegal,
  output logic               halted
);

  localparam int RW = $clog2(NREGS);

  cpu_state_e         state_q, state_d;
  logic [IADDR_W-1:0] pc_q, pc_d;
  logic [IADDR_W-1:0] npc_q, npc_d;
  logic [31:0]        instr_q, instr_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               wen_q, wen_d;
  logic [RW-1:0]      wsel_q, wsel_d;
  logic               bad_q, bad_d;
  logic               ireq_q, ireq_d;
  logic               dreq_q, dreq_d;
  logic               dwe_q, dwe_d;
  logic [DADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0]  dwdata_q, dwdata_d;
  logic               retire_q, retire_d;
  logic               illegal_q, illegal_d;
  logic               halted_q, halted_d;

  logic [DATA_W-1:0]  rf_q [NREGS];

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [RW-1:0]      rs;
  logic [RW-1:0]      rt;
  logic [RW-1:0]      rd;
  logic [4:0]         shamt;
  logic [15:0]        imm;
  logic [5:0]         alu_fn;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_zero;
  logic [DADDR_W-1:0] maddr;

  assign op    = instr_q[OP_LSB +: 6];
  assign rs    = instr_q[RS_LSB +: RW];
  assign rt    = instr_q[RT_LSB +: RW];
  assign rd    = instr_q[RD_LSB +: RW];
  assign shamt = instr_q[SH_LSB +: 5];
  assign funct = instr_q[5:0];
  assign imm   = instr_q[15:0];

  // branches compare through the ALU's subtract path
  assign alu_fn = (op == OP_RTYPE) ? funct : F_SUB;
  assign maddr  = DADDR_W'(a_q) + DADDR_W'($signed(imm));

  cpu_mc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .shamt  (shamt),
    .funct  (alu_fn),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    wen_d     = wen_q;
    wsel_d    = wsel_q;
    bad_d     = bad_q;
    ireq_d    = ireq_q;
    dreq_d    = dreq_q;
    dwe_d     = dwe_q;
    daddr_d   = daddr_q;
    dwdata_d  = dwdata_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    halted_d  = halted_q;
    unique case (state_q)
      S_FETCH: begin
        if (!ireq_q) begin
          ireq_d = 1'b1;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          ireq_d  = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        bad_d = !op_legal(op, funct);
        if (op == OP_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        npc_d   = pc_q + IADDR_W'(1);
        res_d   = alu_res;
        wen_d   = 1'b0;
        wsel_d  = rt;
        state_d = S_WB;
        if (!bad_q) begin
          case (op)
            OP_RTYPE: begin
              wen_d  = 1'b1;
              wsel_d = rd;
            end
            OP_LI: begin
              wen_d = 1'b1;
              res_d = DATA_W'(imm);
            end
            OP_LW, OP_SW: begin
              wen_d    = (op == OP_LW);
              dreq_d   = 1'b1;
              dwe_d    = (op == OP_SW);
              daddr_d  = maddr;
              dwdata_d = b_q;
              state_d  = S_MEM;
            end
            OP_BEQ: if (alu_zero) npc_d = IADDR_W'(imm);
            OP_BNE: if (!alu_zero) npc_d = IADDR_W'(imm);
            OP_J:   npc_d = IADDR_W'(instr_q[25:0]);
            default: ;
          endcase
        end
        if (state_d == S_WB) begin
          retire_d  = 1'b1;
          illegal_d = bad_q;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          dreq_d   = 1'b0;
          dwe_d    = 1'b0;
          retire_d = 1'b1;
          state_d  = S_WB;
          if (!dwe_q) res_d = dmem_rdata;
        end
      end
      S_WB: begin
        pc_d    = npc_q;
        ireq_d  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      npc_q     <= '0;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      wen_q     <= 1'b0;
      wsel_q    <= '0;
      bad_q     <= 1'b0;
      ireq_q    <= 1'b0;
      dreq_q    <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= '0;
      dwdata_q  <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      wen_q     <= wen_d;
      wsel_q    <= wsel_d;
      bad_q     <= bad_d;
      ireq_q    <= ireq_d;
      dreq_q    <= dreq_d;
      dwe_q     <= dwe_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  // entry 0 is never written, so it always reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (state_q == S_WB && wen_q && wsel_q != '0) begin
      rf_q[wsel_q] <= res_q;
    end
  end

  assign imem_req   = ireq_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dreq_q;
  assign dmem_we    = dwe_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign retire     = retire_q;
  assign illegal    = illegal_q;
  assign halted     = halted_q;

endmodule
